// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared branch compare codes and prediction-counter helpers
// Purpose: compare-op encoding for the branch unit, the counter reset value and
//          the 2-bit saturating counter step function.
// Ports:   none (package)
package cpu_pkg;

  typedef enum logic [2:0] {
    CMP_BEQ  = 3'd0,
    CMP_BNE  = 3'd1,
    CMP_BLEZ = 3'd2,
    CMP_BGTZ = 3'd3,
    CMP_BLTZ = 3'd4,
    CMP_BGEZ = 3'd5,
    CMP_RSV6 = 3'd6,
    CMP_RSV7 = 3'd7
  } cmp_op_e;

  // Weak not-taken: one taken outcome flips the prediction.
  localparam logic [1:0] CTR_INIT = 2'b01;

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
    if (taken) begin
      return (c == 2'b11) ? c : c + 2'b01;
    end else begin
      return (c == 2'b00) ? c : c - 2'b01;
    end
  endfunction

endpackage

// File: rtl/branch_resolve_bht_if.sv
// rtl/branch_resolve_bht_if.sv - lookup/resolve/result bundle of the branch unit
// Purpose: groups the IF lookup, the ID resolve request and the registered result.
// Ports:   master = pipeline side (drives lookup pc, request, stall, flush)
//          slave  = branch unit (drives lk_taken, res_*, miss_count)
interface branch_resolve_bht_if #(
  parameter int WIDTH  = 32,
  parameter int PC_W   = 32,
  parameter int MISS_W = 16
);
  logic [PC_W-1:0]   lk_pc;
  logic              lk_taken;
  logic              req_valid;
  logic [PC_W-1:0]   req_pc;
  logic [WIDTH-1:0]  req_a;
  logic [WIDTH-1:0]  req_b;
  logic [2:0]        req_cmp_op;
  logic              req_pred;
  logic              stall;
  logic              flush;
  logic              res_valid;
  logic              res_taken;
  logic              res_mispredict;
  logic [MISS_W-1:0] miss_count;

  modport master (
    output lk_pc, req_valid, req_pc, req_a, req_b, req_cmp_op, req_pred, stall, flush,
    input  lk_taken, res_valid, res_taken, res_mispredict, miss_count
  );

  modport slave (
    input  lk_pc, req_valid, req_pc, req_a, req_b, req_cmp_op, req_pred, stall, flush,
    output lk_taken, res_valid, res_taken, res_mispredict, miss_count
  );
endinterface

// File: rtl/branch_resolve_bht_cmp.sv
// rtl/branch_resolve_bht_cmp.sv - combinational branch condition evaluator
// Purpose: evaluates the six branch conditions; reserved codes are not taken.
// Ports:   a, b (WIDTH operands), op (compare code) -> taken
module branch_cmp
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             taken
);
  logic a_neg;
  logic a_zero;

  // Signed tests against zero reduce to the sign bit and a zero detect,
  // which avoids mixing signed and unsigned operands in a relational compare.
  assign a_neg  = a[WIDTH-1];
  assign a_zero = ~|a;

  always_comb begin
    taken = 1'b0;
    case (cmp_op_e'(op))
      CMP_BEQ:  taken = (a == b);
      CMP_BNE:  taken = (a != b);
      CMP_BLEZ: taken = a_neg | a_zero;
      CMP_BGTZ: taken = ~a_neg & ~a_zero;
      CMP_BLTZ: taken = a_neg;
      CMP_BGEZ: taken = ~a_neg;
      default:  taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_resolve_bht.sv
// rtl/branch_resolve_bht.sv - branch resolution with 2-bit counter history table
// Purpose: resolves branches one cycle after acceptance, trains a table of
//          saturating counters indexed by pc[IDX_W+1:2] and counts mispredicts.
// Ports:   clk, rst_n (async active-low)
//          bus (slave): lk_pc -> lk_taken (combinational table read);
//          req_* / stall / flush in; res_valid, res_taken, res_mispredict,
//          miss_count out (registered).
module branch_resolve_bht
  import cpu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int PC_W   = 32,
  parameter int IDX_W  = 6,
  parameter int MISS_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_bht_if.slave  bus
);
  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]        ctr [DEPTH];
  logic [IDX_W-1:0]  lk_idx;
  logic [IDX_W-1:0]  upd_idx;
  logic              cond;
  logic              accept;
  logic              res_valid_q;
  logic              res_taken_q;
  logic              res_mispredict_q;
  logic [MISS_W-1:0] miss_q;
  logic              unused_pc_bits;

  assign lk_idx  = bus.lk_pc[IDX_W+1:2];
  assign upd_idx = bus.req_pc[IDX_W+1:2];
  // Only the index slice of each pc matters; the rest is folded away here.
  assign unused_pc_bits = ^{bus.lk_pc, bus.req_pc};

  branch_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a     (bus.req_a),
    .b     (bus.req_b),
    .op    (bus.req_cmp_op),
    .taken (cond)
  );

  // Flush dominates stall: a flushed request is never accepted.
  assign accept = bus.req_valid & ~bus.stall & ~bus.flush;

  // Read before the edge: a same-cycle update to this entry is not visible.
  assign bus.lk_taken = ctr[lk_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr[i] <= CTR_INIT;
      end
    end else if (accept) begin
      ctr[upd_idx] <= ctr_step(ctr[upd_idx], cond);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      miss_q           <= '0;
    end else if (bus.flush) begin
      res_valid_q <= 1'b0;
    end else if (bus.stall) begin
      res_valid_q <= res_valid_q;
    end else if (bus.req_valid) begin
      res_valid_q      <= 1'b1;
      res_taken_q      <= cond;
      res_mispredict_q <= cond ^ bus.req_pred;
      if ((cond ^ bus.req_pred) && (miss_q != {MISS_W{1'b1}})) begin
        miss_q <= miss_q + 1'b1;
      end
    end else begin
      // Idle slot: result becomes invalid but the last outcome stays readable.
      res_valid_q <= 1'b0;
    end
  end

  assign bus.res_valid      = res_valid_q;
  assign bus.res_taken      = res_taken_q;
  assign bus.res_mispredict = res_mispredict_q;
  assign bus.miss_count     = miss_q;
endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb/tb_branch_resolve_bht.sv - scoreboard bench for branch_resolve_bht
module tb_branch_resolve_bht;
  localparam int WIDTH  = 32;
  localparam int PC_W   = 32;
  localparam int IDX_W  = 6;
  localparam int MISS_W = 2;
  localparam int NO_LK  = -1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_bht_if #(.WIDTH(WIDTH), .PC_W(PC_W), .MISS_W(MISS_W)) bus ();

  branch_resolve_bht #(
    .WIDTH(WIDTH), .PC_W(PC_W), .IDX_W(IDX_W), .MISS_W(MISS_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int                due;
    logic              v;
    logic              t;
    logic              m;
    logic [MISS_W-1:0] miss;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  logic              mv, mt, mm;
  logic [MISS_W-1:0] mmiss;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: each expectation is due on a given cycle and compared at that negedge.
  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        mon_e = q.pop_front();
        tests++;
        fails++;
        $display("FAIL missed_result: due cycle %0d not checked by cycle %0d", mon_e.due, cyc);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        mon_e = q.pop_front();
        chk("res_valid", bus.res_valid, mon_e.v);
        if (mon_e.v) begin
          chk("res_taken", bus.res_taken, mon_e.t);
          chk("res_mispredict", bus.res_mispredict, mon_e.m);
        end
        chk("miss_count", bus.miss_count, mon_e.miss);
      end
    end
  end

  task automatic model_reset();
    mv = 1'b0; mt = 1'b0; mm = 1'b0; mmiss = '0;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, bus.res_valid, 0);
    chk({name, "_taken"}, bus.res_taken, 0);
    chk({name, "_mis"}, bus.res_mispredict, 0);
    chk({name, "_miss"}, bus.miss_count, 0);
  endtask

  // One cycle of stimulus; cond is the hand-computed outcome, exp_lk the
  // hand-computed prediction at lkpc seen before this cycle's update.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] op, input logic pred,
                      input logic st, input logic fl, input logic cond,
                      input logic [31:0] lkpc, input int exp_lk, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    bus.req_valid  = v;
    bus.req_pc     = pc;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_cmp_op = op;
    bus.req_pred   = pred;
    bus.stall      = st;
    bus.flush      = fl;
    bus.lk_pc      = lkpc;
    if (fl) begin
      mv = 1'b0;
    end else if (st) begin
      mv = mv;
    end else if (v) begin
      mv = 1'b1;
      mt = cond;
      mm = cond ^ pred;
      if (mm && mmiss != {MISS_W{1'b1}}) mmiss = mmiss + 1'b1;
    end else begin
      mv = 1'b0;
    end
    e.due = cyc + 1; e.v = mv; e.t = mt; e.m = mm; e.miss = mmiss;
    q.push_back(e);
    if (exp_lk >= 0) begin
      #1;
      chk({name, "_lk"}, bus.lk_taken, exp_lk[0]);
    end
  endtask

  initial begin
    int k;
    bus.lk_pc = '0; bus.req_valid = 1'b0; bus.req_pc = '0; bus.req_a = '0;
    bus.req_b = '0; bus.req_cmp_op = '0; bus.req_pred = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk_zero("reset");
    bus.lk_pc = 32'h40;
    #1;
    chk("reset_lk", bus.lk_taken, 0);
    rst_n = 1'b1;

    // BEQ equal, predicted not taken -> mispredict
    step(1, 32'h100, 5, 5, 3'd0, 0, 0, 0, 1, 32'h100, 0, "beq_eq");
    // Four taken BNE at 0x40: counter 01->10->11->11
    step(1, 32'h40, 1, 2, 3'd1, 1, 0, 0, 1, 32'h40, 0, "bne1");
    step(1, 32'h40, 1, 2, 3'd1, 1, 0, 0, 1, 32'h40, 1, "bne2");
    step(1, 32'h40, 1, 2, 3'd1, 1, 0, 0, 1, 32'h100, 1, "bne3");
    step(1, 32'h40, 1, 2, 3'd1, 1, 0, 0, 1, 32'h40, 1, "bne4");

    // Signed edge conditions
    step(1, 32'h200, 32'h0,        0, 3'd2, 1, 0, 0, 1, 32'h40, 1, "blez0");
    step(1, 32'h200, 32'h80000000, 0, 3'd3, 0, 0, 0, 0, 32'h40, NO_LK, "bgtz_min");
    step(1, 32'h200, 32'hFFFFFFFF, 0, 3'd4, 1, 0, 0, 1, 32'h40, NO_LK, "bltz_m1");
    step(1, 32'h200, 32'h0,        0, 3'd5, 1, 0, 0, 1, 32'h40, NO_LK, "bgez0");
    step(1, 32'h200, 32'h5,        5, 3'd7, 0, 0, 0, 0, 32'h40, NO_LK, "code7");
    step(1, 32'h200, 32'h1,        0, 3'd3, 1, 0, 0, 1, 32'h40, NO_LK, "bgtz1");
    step(1, 32'h200, 32'h7,        7, 3'd1, 0, 0, 0, 0, 32'h40, NO_LK, "bne_eq");

    // Stall holds results and table; flush (alone or with stall) kills the request
    step(1, 32'h80, 3, 3, 3'd0, 0, 1, 0, 1, 32'h80, 0, "stall");
    step(1, 32'h80, 3, 3, 3'd0, 0, 1, 1, 1, 32'h80, 0, "flush_stall");
    step(1, 32'h80, 3, 3, 3'd0, 0, 0, 1, 1, 32'h80, 0, "flush");
    step(0, 32'h80, 3, 3, 3'd0, 0, 0, 0, 0, 32'h80, 0, "idle");

    // 0x140 aliases 0x40 (index 16, counter 11); same-cycle lookup sees old value
    step(1, 32'h140, 1, 2, 3'd0, 0, 0, 0, 0, 32'h40, 1, "alias1");
    step(1, 32'h140, 1, 2, 3'd0, 0, 0, 0, 0, 32'h40, 1, "alias2");
    step(0, 32'h140, 0, 0, 3'd0, 0, 0, 0, 0, 32'h40, 0, "alias_after");

    // Reset while a resolve is presented
    step(1, 32'h40, 1, 2, 3'd1, 0, 0, 0, 1, 32'h40, 0, "pre_rst");
    @(posedge clk);
    #1;
    chk("pre_rst_valid", bus.res_valid, 1);
    chk("pre_rst_lk", bus.lk_taken, 1);
    q.delete();
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    chk("mid_rst_lk", bus.lk_taken, 0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Saturating mispredict counter at MISS_W=2: 1, 2, 3, 3
    step(1, 32'h300, 5, 5, 3'd0, 0, 0, 0, 1, 32'h300, 0, "miss1");
    step(1, 32'h300, 5, 5, 3'd0, 0, 0, 0, 1, 32'h300, 1, "miss2");
    step(1, 32'h300, 5, 5, 3'd0, 0, 0, 0, 1, 32'h300, 1, "miss3");
    step(1, 32'h300, 5, 5, 3'd0, 0, 0, 0, 1, 32'h300, 1, "miss4");
    step(0, 32'h300, 0, 0, 3'd0, 0, 0, 0, 0, 32'h300, 1, "tail");

    k = 0;
    while (q.size() > 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk);
    chk("drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
